// File: rtl/aha_reset_seq_pkg.sv
// Shared state type and counter-sizing helpers for the multi-channel reset sequencer.
package aha_reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    PEND = 2'd2,
    RUN  = 2'd3
  } ch_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Hold counter counts HOLD_CYCLES-1 down to 0; never narrower than one bit.
  function automatic int hold_w(input int hold_cycles);
    return (clog2(hold_cycles) < 1) ? 1 : clog2(hold_cycles);
  endfunction

  function automatic int gap_w(input int gap_cycles);
    return (clog2(gap_cycles + 1) < 1) ? 1 : clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/aha_reset_seq_channel.sv
// One reset channel: HOLD/WAIT/PEND/RUN FSM plus its minimum-hold counter.
// qn/ack are registered; pend feeds the arbiter, run is the next-cycle RUN flag.
module aha_reset_seq_channel
  import aha_reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic grant,
  output logic pend,
  output logic qn,
  output logic ack,
  output logic run
);

  localparam int                HOLD_W      = hold_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  ch_state_e         state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              qn_q, qn_d;
  logic              ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD: begin
        if (cnt_q == '0) state_d = req ? WAIT : PEND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WAIT: if (!req) state_d = PEND;
      // The arbiter never grants a channel whose req is high, so req always wins.
      PEND: begin
        if (req)        state_d = WAIT;
        else if (grant) state_d = RUN;
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = HOLD_RELOAD;
        end
      end
      default: state_d = HOLD;
    endcase
    qn_d  = (state_d == RUN);
    ack_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= HOLD_RELOAD;
      qn_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qn_q    <= qn_d;
      ack_q   <= ack_d;
    end
  end

  assign pend = (state_q == PEND);
  assign qn   = qn_q;
  assign ack  = ack_q;
  assign run  = (state_d == RUN);

endmodule

// File: rtl/aha_reset_sequencer.sv
// Multi-channel reset sequencer: per-channel REQ/ACK handshakes with staggered, lowest-first releases.
// Optional: define AHA_RESET_SEQ_REQ_SYNC_EN to pass each REQ bit through a 2-flop synchronizer.
module aha_reset_sequencer
  import aha_reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [NUM_CH-1:0] REQ,
  output logic [NUM_CH-1:0] ACK,
  output logic [NUM_CH-1:0] Qn,
  output logic              BUSY
);

  localparam int               GAP_W      = gap_w(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES);

  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] run_nxt;
  logic [NUM_CH-1:0] grant;
  logic              granted;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              busy_q, busy_d;

`ifdef AHA_RESET_SEQ_REQ_SYNC_EN
  logic [NUM_CH-1:0] req_meta_q, req_meta_d;
  logic [NUM_CH-1:0] req_sync_q, req_sync_d;

  always_comb begin
    req_meta_d = REQ;
    req_sync_d = req_meta_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
    end else begin
      req_meta_q <= req_meta_d;
      req_sync_q <= req_sync_d;
    end
  end

  assign req_s = req_sync_q;
`else
  assign req_s = REQ;
`endif

  // Single grant per cycle to the lowest pending channel whose request is low.
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    if (gap_q == '0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!granted && pend[i] && !req_s[i]) begin
          grant[i] = 1'b1;
          granted  = 1'b1;
        end
      end
    end
    gap_d = gap_q;
    if (granted)           gap_d = GAP_RELOAD;
    else if (gap_q != '0)  gap_d = gap_q - 1'b1;
    busy_d = ~&run_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      gap_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      gap_q  <= gap_d;
      busy_q <= busy_d;
    end
  end

  assign BUSY = busy_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aha_reset_seq_channel #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch (
      .clk  (CLK),
      .rst_n(RESETn),
      .req  (req_s[i]),
      .grant(grant[i]),
      .pend (pend[i]),
      .qn   (Qn[i]),
      .ack  (ACK[i]),
      .run  (run_nxt[i])
    );
  end

endmodule
